// File: rtl/palette_pkg.sv
// Shared definitions for the palette/DAC stage: register map, write-phase
// encoding and the EGA default palette loaded at reset.
package palette_pkg;

  localparam logic [1:0] ADDR_INDEX = 2'd0;
  localparam logic [1:0] ADDR_DATA  = 2'd1;
  localparam logic [1:0] ADDR_MASK  = 2'd2;

  typedef enum logic [1:0] {
    PH_R,
    PH_G,
    PH_B
  } phase_t;

  typedef struct packed {
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
  } rgb_t;

  // bit2 = red, bit1 = green, bit0 = blue at 0x2A; bit3 adds 0x15; entry 6 is brown
  localparam rgb_t DEFAULT_PALETTE [16] = '{
    '{6'h00, 6'h00, 6'h00},
    '{6'h00, 6'h00, 6'h2A},
    '{6'h00, 6'h2A, 6'h00},
    '{6'h00, 6'h2A, 6'h2A},
    '{6'h2A, 6'h00, 6'h00},
    '{6'h2A, 6'h00, 6'h2A},
    '{6'h2A, 6'h15, 6'h00},
    '{6'h2A, 6'h2A, 6'h2A},
    '{6'h15, 6'h15, 6'h15},
    '{6'h15, 6'h15, 6'h3F},
    '{6'h15, 6'h3F, 6'h15},
    '{6'h15, 6'h3F, 6'h3F},
    '{6'h3F, 6'h15, 6'h15},
    '{6'h3F, 6'h15, 6'h3F},
    '{6'h3F, 6'h3F, 6'h15},
    '{6'h3F, 6'h3F, 6'h3F}
  };

endpackage

// File: rtl/palette_dac_if.sv
// CPU register-write bus into the palette stage.
interface palette_dac_if;

  logic [7:0] cpu_data;
  logic [1:0] cpu_address;
  logic       wr_en;

  modport master (
    output cpu_data,
    output cpu_address,
    output wr_en
  );

  modport slave (
    input cpu_data,
    input cpu_address,
    input wr_en
  );

endinterface

// File: rtl/palette_regs.sv
// CPU-side register file: write decode, R/G/B write-phase FSM, hold registers,
// pixel mask and the 16-entry palette with a combinational read port.
module palette_regs
  import palette_pkg::*;
#(
  parameter int unsigned DAC_WIDTH = 6
) (
  input  logic                 pixel_clk,
  input  logic                 reset,
  palette_dac_if.slave         cpu,
  input  logic [3:0]           read_index,
  output logic [3:0]           mask,
  output logic [DAC_WIDTH-1:0] read_r,
  output logic [DAC_WIDTH-1:0] read_g,
  output logic [DAC_WIDTH-1:0] read_b
);

  logic [DAC_WIDTH-1:0] pal_r [16];
  logic [DAC_WIDTH-1:0] pal_g [16];
  logic [DAC_WIDTH-1:0] pal_b [16];

  logic [DAC_WIDTH-1:0] hold_r;
  logic [DAC_WIDTH-1:0] hold_g;
  logic [DAC_WIDTH-1:0] wr_value;
  logic [3:0]           wr_index;

  phase_t phase_q;
  phase_t phase_d;

  logic write_index;
  logic write_data;
  logic write_mask;
  logic commit;

  assign wr_value    = DAC_WIDTH'(cpu.cpu_data);
  assign write_index = cpu.wr_en && (cpu.cpu_address == ADDR_INDEX);
  assign write_data  = cpu.wr_en && (cpu.cpu_address == ADDR_DATA);
  assign write_mask  = cpu.wr_en && (cpu.cpu_address == ADDR_MASK);
  assign commit      = write_data && (phase_q == PH_B);

  always_comb begin
    phase_d = phase_q;
    if (write_index) begin
      phase_d = PH_R;
    end else if (write_data) begin
      unique case (phase_q)
        PH_R:    phase_d = PH_G;
        PH_G:    phase_d = PH_B;
        default: phase_d = PH_R;
      endcase
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      phase_q  <= PH_R;
      wr_index <= '0;
      mask     <= '1;
      hold_r   <= '0;
      hold_g   <= '0;
      for (int unsigned i = 0; i < 16; i++) begin
        pal_r[i] <= DAC_WIDTH'(DEFAULT_PALETTE[i].r);
        pal_g[i] <= DAC_WIDTH'(DEFAULT_PALETTE[i].g);
        pal_b[i] <= DAC_WIDTH'(DEFAULT_PALETTE[i].b);
      end
    end else begin
      phase_q <= phase_d;
      if (write_index) begin
        wr_index <= cpu.cpu_data[3:0];
        hold_r   <= '0;
        hold_g   <= '0;
      end
      if (write_mask) begin
        mask <= cpu.cpu_data[3:0];
      end
      if (write_data && phase_q == PH_R) begin
        hold_r <= wr_value;
      end
      if (write_data && phase_q == PH_G) begin
        hold_g <= wr_value;
      end
      // the 4-bit index wraps 15 -> 0 on its own
      if (commit) begin
        pal_r[wr_index] <= hold_r;
        pal_g[wr_index] <= hold_g;
        pal_b[wr_index] <= wr_value;
        wr_index        <= wr_index + 4'd1;
      end
    end
  end

  assign read_r = pal_r[read_index];
  assign read_g = pal_g[read_index];
  assign read_b = pal_b[read_index];

endmodule

// File: rtl/palette_dac.sv
// Palette lookup and DAC feed: two-stage pipeline keeping RGB levels and the
// forwarded sync/blank signals aligned.
module palette_dac
  import palette_pkg::*;
#(
  parameter int unsigned DAC_WIDTH = 6
) (
  input  logic                 pixel_clk,
  input  logic                 reset,
  palette_dac_if.slave         cpu,
  input  logic [3:0]           colour_index,
  input  logic                 n_blank_in,
  input  logic                 n_hsync_in,
  input  logic                 vsync_in,
  output logic [DAC_WIDTH-1:0] red,
  output logic [DAC_WIDTH-1:0] green,
  output logic [DAC_WIDTH-1:0] blue,
  output logic                 n_hsync_out,
  output logic                 vsync_out,
  output logic                 n_blank_out
);

  logic [3:0]           mask;
  logic [3:0]           index_s1;
  logic                 n_blank_s1;
  logic                 n_hsync_s1;
  logic                 vsync_s1;
  logic [DAC_WIDTH-1:0] look_r;
  logic [DAC_WIDTH-1:0] look_g;
  logic [DAC_WIDTH-1:0] look_b;

  palette_regs #(
    .DAC_WIDTH (DAC_WIDTH)
  ) u_regs (
    .pixel_clk  (pixel_clk),
    .reset      (reset),
    .cpu        (cpu),
    .read_index (index_s1),
    .mask       (mask),
    .read_r     (look_r),
    .read_g     (look_g),
    .read_b     (look_b)
  );

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      index_s1   <= '0;
      n_blank_s1 <= 1'b0;
      n_hsync_s1 <= 1'b1;
      vsync_s1   <= 1'b0;
    end else begin
      index_s1   <= colour_index & mask;
      n_blank_s1 <= n_blank_in;
      n_hsync_s1 <= n_hsync_in;
      vsync_s1   <= vsync_in;
    end
  end

  // a commit on this edge is not yet visible to the read, so the pre-commit value is taken
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      n_blank_out <= 1'b0;
      n_hsync_out <= 1'b1;
      vsync_out   <= 1'b0;
    end else begin
      red         <= n_blank_s1 ? look_r : '0;
      green       <= n_blank_s1 ? look_g : '0;
      blue        <= n_blank_s1 ? look_b : '0;
      n_blank_out <= n_blank_s1;
      n_hsync_out <= n_hsync_s1;
      vsync_out   <= vsync_s1;
    end
  end

endmodule
